// File: rtl/ahb2apb_bridge.sv
// ahb2apb_bridge: AHB-Lite slave to multi-slave APB bridge.
// Ports: HCLK, HRESET (sync, active-high); HSEL/HADDR/HTRANS/HWRITE/
//   HWDATA/HREADY in, HREADYOUT/HRESP/HRDATA out (AHB-Lite slave);
//   PADDR/PWDATA/PWRITE/PENABLE/PSEL out, PRDATA/PREADY/PSLVERR in (APB).
// Define AHB2APB_TIMEOUT_EN to bound ACCESS at TIMEOUT_CYC stall cycles.
module ahb2apb_bridge #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NUM_SLV        = 4,
  parameter int TIMEOUT_CYC    = 256
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      HSEL,
  input  logic [31:0]               HADDR,
  input  logic [1:0]                HTRANS,
  input  logic                      HWRITE,
  input  logic [31:0]               HWDATA,
  input  logic                      HREADY,
  output logic                      HREADYOUT,
  output logic                      HRESP,
  output logic [31:0]               HRDATA,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PENABLE,
  output logic [NUM_SLV-1:0]        PSEL,
  input  logic [NUM_SLV*32-1:0]     PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR
);

  localparam int IDXW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam logic [IDXW:0] NSLV_W = (IDXW+1)'(NUM_SLV);

  typedef enum logic [2:0] {
    S_IDLE, S_CAPT, S_SETUP, S_ACCESS, S_DONE, S_ERR1, S_ERR2
  } state_t;

  state_t                    r_state;
  logic                      r_hreadyout;
  logic                      r_hresp;
  logic [31:0]               r_hrdata;
  logic [APB_ADDR_WIDTH-1:0] r_paddr;
  logic [31:0]               r_pwdata;
  logic                      r_pwrite;
  logic                      r_penable;
  logic [NUM_SLV-1:0]        r_psel;
  logic [IDXW-1:0]           r_idx;

  logic [IDXW-1:0]           w_idx;
  logic                      w_accept;
  logic                      w_bad;
  logic                      w_pready;
  logic                      w_pslverr;
  logic [31:0]               w_prdata;
  logic [NUM_SLV-1:0]        w_onehot;
  logic                      w_unused;

  if (NUM_SLV > 1) begin : g_dec
    assign w_idx = HADDR[APB_ADDR_WIDTH +: IDXW];
  end else begin : g_nodec
    assign w_idx = '0;
  end

  // A new address phase is only taken in states where the AHB
  // data phase of the previous transfer is completing.
  assign w_accept = HSEL && HTRANS[1] && HREADY &&
                    (r_state == S_IDLE || r_state == S_DONE ||
                     r_state == S_ERR2);

  // Only reachable for non-power-of-two slave counts.
  assign w_bad     = ({1'b0, r_idx} >= NSLV_W);
  assign w_pready  = PREADY[r_idx];
  assign w_pslverr = PSLVERR[r_idx];
  assign w_prdata  = PRDATA[{r_idx, 5'b0} +: 32];
  assign w_onehot  = NUM_SLV'(1) << r_idx;
  assign w_unused  = ^{HADDR, HTRANS[0], 32'(TIMEOUT_CYC)};

`ifdef AHB2APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] r_tmo;
  logic          w_tmo;
  assign w_tmo = (r_tmo == TMO_LAST);
`endif

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state     <= S_IDLE;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
      r_hrdata    <= '0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pwrite    <= 1'b0;
      r_penable   <= 1'b0;
      r_psel      <= '0;
      r_idx       <= '0;
`ifdef AHB2APB_TIMEOUT_EN
      r_tmo       <= '0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE, S_ERR2: begin
          r_hresp <= 1'b0;
          if (w_accept) begin
            r_state     <= S_CAPT;
            r_hreadyout <= 1'b0;
            r_paddr     <= HADDR[APB_ADDR_WIDTH-1:0];
            r_pwrite    <= HWRITE;
            r_idx       <= w_idx;
          end else begin
            r_state     <= S_IDLE;
            r_hreadyout <= 1'b1;
          end
        end
        S_CAPT: begin
          r_pwdata <= HWDATA;
          if (w_bad) begin
            r_state <= S_ERR1;
            r_hresp <= 1'b1;
          end else begin
            r_state <= S_SETUP;
            r_psel  <= w_onehot;
          end
        end
        S_SETUP: begin
          r_state   <= S_ACCESS;
          r_penable <= 1'b1;
        end
        S_ACCESS: begin
          if (w_pready) begin
            r_psel    <= '0;
            r_penable <= 1'b0;
            if (w_pslverr) begin
              r_state <= S_ERR1;
              r_hresp <= 1'b1;
            end else begin
              r_state     <= S_DONE;
              r_hreadyout <= 1'b1;
              if (!r_pwrite) r_hrdata <= w_prdata;
            end
          end
`ifdef AHB2APB_TIMEOUT_EN
          else if (w_tmo) begin
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_state   <= S_ERR1;
            r_hresp   <= 1'b1;
          end
`endif
        end
        S_ERR1: begin
          r_state     <= S_ERR2;
          r_hreadyout <= 1'b1;
        end
        default: begin
          r_state     <= S_IDLE;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b0;
        end
      endcase
`ifdef AHB2APB_TIMEOUT_EN
      if (r_state == S_ACCESS && !w_pready && !w_tmo)
        r_tmo <= r_tmo + TW'(1);
      else
        r_tmo <= '0;
`endif
    end
  end

  assign HREADYOUT = r_hreadyout;
  assign HRESP     = r_hresp;
  assign HRDATA    = r_hrdata;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign PWRITE    = r_pwrite;
  assign PENABLE   = r_penable;
  assign PSEL      = r_psel;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// tb_ahb2apb_bridge: directed + random transfers against a
// transaction-level expectation of the bridge's AHB/APB behaviour.
module tb_ahb2apb_bridge;

  logic         HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic         HRESET, HSEL, HSEL3, HWRITE, HREADY;
  logic [31:0]  HADDR, HWDATA;
  logic [1:0]   HTRANS;
  logic [127:0] PRDATA;
  logic [3:0]   PREADY, PSLVERR;

  logic         HREADYOUT, HRESP, PWRITE, PENABLE;
  logic [31:0]  HRDATA, PWDATA;
  logic [11:0]  PADDR;
  logic [3:0]   PSEL;

  logic         h3_rdy, h3_resp, p3_write, p3_en;
  logic [31:0]  h3_rdata, p3_wdata;
  logic [11:0]  p3_addr;
  logic [2:0]   p3_sel;

  int           checks = 0;
  int           errors = 0;
  logic [31:0]  exp_rd [2];

  ahb2apb_bridge #(.APB_ADDR_WIDTH(12), .NUM_SLV(4), .TIMEOUT_CYC(8)) u_dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PENABLE(PENABLE),
    .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  ahb2apb_bridge #(.APB_ADDR_WIDTH(12), .NUM_SLV(3)) u_dut3 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL3), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(h3_rdy), .HRESP(h3_resp), .HRDATA(h3_rdata),
    .PADDR(p3_addr), .PWDATA(p3_wdata), .PWRITE(p3_write),
    .PENABLE(p3_en), .PSEL(p3_sel), .PRDATA(PRDATA[95:0]),
    .PREADY(PREADY[2:0]), .PSLVERR(PSLVERR[2:0])
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {HREADYOUT, HRESP, PENABLE, PSEL[3:0]}
  function automatic logic [6:0] ctl(input bit u);
    return u ? {h3_rdy, h3_resp, p3_en, 1'b0, p3_sel}
             : {HREADYOUT, HRESP, PENABLE, PSEL};
  endfunction

  function automatic logic [44:0] apb(input bit u);
    return u ? {p3_addr, p3_write, p3_wdata} : {PADDR, PWRITE, PWDATA};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      HSEL   = 1'($urandom);
      HSEL3  = 1'($urandom);
      HREADY = 1'($urandom);
      HTRANS = HREADY ? {1'b0, 1'($urandom)} : 2'($urandom);
      HADDR  = $urandom;
      @(posedge HCLK);
      @(negedge HCLK);
      chk("idle", ctl(0), 7'b100_0000);
      chk("idle3", ctl(1), 7'b100_0000);
    end
    HSEL  = 1'b0;
    HSEL3 = 1'b0;
    HTRANS = 2'b00;
  endtask

  // One AHB transfer with a slave that inserts w wait cycles.
  // Called at a negedge; returns after the final response cycle.
  task automatic xfer(input bit u, input logic [31:0] addr, input bit wr,
                      input int w, input bit err, input bit stuck,
                      input logic [31:0] wd, input logic [31:0] rd);
    int         nslv = u ? 3 : 4;
    int         idx  = int'(addr[13:12]);
    bit         bad  = (idx >= nslv);
    logic [3:0] oh   = bad ? 4'b0 : 4'(1 << idx);
    int         last = bad ? 3 : (err ? 5 + w : 4 + w);
    logic [6:0] e;
    HSEL   = !u;
    HSEL3  = u;
    HTRANS = 2'b10;
    HADDR  = addr;
    HWRITE = wr;
    HREADY = 1'b1;
    for (int c = 1; c <= last; c++) begin
      @(posedge HCLK);
      #1;
      if (c == 1) begin
        HSEL   = 1'b0;
        HSEL3  = 1'b0;
        HTRANS = 2'b00;
        HADDR  = $urandom;
        HWRITE = 1'($urandom);
        HWDATA = wd;
      end else begin
        HWDATA = $urandom;
      end
      PRDATA  = {$urandom, $urandom, $urandom, $urandom};
      PREADY  = 4'($urandom);
      PSLVERR = 4'($urandom);
      if (!bad) begin
        PREADY[idx]  = !stuck && (c >= 3 + w);
        PSLVERR[idx] = err;
        if (c == 3 + w) PRDATA[32*idx +: 32] = rd;
      end
      @(negedge HCLK);
      if (bad)
        e = (c == 2) ? 7'b010_0000 : (c == 3) ? 7'b110_0000 : 7'b0;
      else if (c == 2)
        e = {3'b000, oh};
      else if (c >= 3 && c <= 3 + w)
        e = {3'b001, oh};
      else if (c == 4 + w)
        e = err ? 7'b010_0000 : 7'b100_0000;
      else if (c == 5 + w)
        e = 7'b110_0000;
      else
        e = 7'b0;
      chk($sformatf("ctl u%0d a%h c%0d", u, addr, c), ctl(u), e);
      if (!bad && c >= 2 && c <= 3 + w)
        chk($sformatf("apb u%0d c%0d", u, c), apb(u), {addr[11:0], wr, wd});
    end
    if (!bad && !err && !wr) exp_rd[u] = rd;
    chk($sformatf("hrdata u%0d", u), u ? h3_rdata : HRDATA, exp_rd[u]);
    PREADY  = 4'b0;
    PSLVERR = 4'b0;
  endtask

  initial begin
    HRESET = 1'b1;
    HSEL   = 1'b0;
    HSEL3  = 1'b0;
    HTRANS = 2'b00;
    HADDR  = '0;
    HWRITE = 1'b0;
    HWDATA = '0;
    HREADY = 1'b1;
    PRDATA = '0;
    PREADY = '0;
    PSLVERR = '0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;

    @(negedge HCLK);
    chk("rst_ctl", {ctl(0), PWRITE, PADDR}, {7'b100_0000, 1'b0, 12'h0});
    chk("rst_data", {HRDATA, PWDATA}, 64'h0);
    @(posedge HCLK);
    #1 HRESET = 1'b0;
    @(negedge HCLK);
    idle(3);

    xfer(0, 32'h0000_1004, 1, 0, 0, 0, 32'hDEAD_BEEF, $urandom);
    idle(1);
    xfer(0, 32'h0000_0010, 0, 3, 0, 0, $urandom, 32'h1234_5678);
    xfer(0, 32'h0000_2000, 1, 1, 1, 0, $urandom, $urandom);
    xfer(0, 32'h0000_2008, 0, 0, 0, 0, $urandom, 32'hA5A5_0F0F);
    idle(2);
    xfer(1, 32'h0000_3000, 0, 0, 0, 0, $urandom, $urandom);
    xfer(1, 32'h0000_2ABC, 0, 2, 0, 0, $urandom, 32'h0BAD_F00D);

    for (int i = 0; i < 40; i++) begin
      xfer(1'($urandom), $urandom, 1'($urandom),
           int'($urandom_range(0, 4)), ($urandom_range(0, 3) == 0),
           0, $urandom, $urandom);
      idle(int'($urandom_range(0, 2)));
    end

`ifdef AHB2APB_TIMEOUT_EN
    idle(1);
    xfer(0, 32'h0000_3010, 1, 7, 1, 1, $urandom, $urandom);
`endif

    xfer(0, 32'h0000_0020, 0, 0, 0, 0, $urandom, 32'hCAFE_0001);
    idle(1);

    // Stalled slave 1 read, then reset in the middle of ACCESS.
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HADDR  = 32'h0000_1000;
    HWRITE = 1'b0;
    HREADY = 1'b1;
    @(posedge HCLK);
    #1;
    HSEL    = 1'b0;
    HTRANS  = 2'b00;
    PREADY  = 4'b1101;
    PSLVERR = 4'b0000;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    chk("stall", ctl(0), {3'b001, 4'b0010});
`ifndef AHB2APB_TIMEOUT_EN
    repeat (1000) @(posedge HCLK);
    @(negedge HCLK);
    chk("wait1000", ctl(0), {3'b001, 4'b0010});
`endif
    HRESET = 1'b1;
    @(posedge HCLK);
    #1 HRESET = 1'b0;
    PREADY = 4'b0;
    @(negedge HCLK);
    chk("abort_ctl", ctl(0), 7'b100_0000);
    chk("abort_hrdata", HRDATA, 32'h0);
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    idle(2);
    xfer(0, 32'h0000_1FFC, 0, 1, 0, 0, $urandom, 32'h7777_1111);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
